// File: rtl/game_sprite_display_scaled_pkg.sv
// game_sprite_display_scaled_pkg: shared widths and the latched sprite attribute record.
`include "game_config.vh"
package game_sprite_display_scaled_pkg;
    localparam int XW = `X_WIDTH;
    localparam int YW = `Y_WIDTH;
    localparam int RGBW = `RGB_WIDTH;
    localparam int SCR_W = `SCREEN_WIDTH;
    localparam int SCR_H = `SCREEN_HEIGHT;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [1:0]    s;
        logic          mx;
        logic          my;
    } sprite_attr_t;

    // Scale code 3 is reserved and behaves as x1.
    function automatic logic [1:0] shift_of(input logic [1:0] scale);
        return (scale == 2'd3) ? 2'd0 : scale;
    endfunction
endpackage

// File: rtl/game_config.vh
// game_config: screen geometry and colour widths shared by the video blocks.
`ifndef GAME_CONFIG_VH
`define GAME_CONFIG_VH
`define X_WIDTH 10
`define Y_WIDTH 10
`define RGB_WIDTH 3
`define SCREEN_WIDTH 640
`define SCREEN_HEIGHT 480
`endif

// File: rtl/game_sprite_display_scaled_bitmap_rom.sv
// game_sprite_bitmap_rom: constant sprite bitmap, (row, column) -> {enable, rgb}.
module game_sprite_bitmap_rom
    import game_sprite_display_scaled_pkg::*;
#(
    parameter int SPRITE_WIDTH = 8,
    parameter int SPRITE_HEIGHT = 8,
    parameter logic [SPRITE_HEIGHT*SPRITE_WIDTH*(1+RGBW)-1:0] BITMAP = '0
) (
    input  logic [$clog2(SPRITE_HEIGHT)-1:0] row,
    input  logic [$clog2(SPRITE_WIDTH)-1:0]  col,
    output logic                             en,
    output logic [RGBW-1:0]                  rgb
);
    localparam int EW = 1 + RGBW;
    localparam int NE = SPRITE_HEIGHT * SPRITE_WIDTH;

    logic [EW-1:0] entries [NE];

    // Entry 0 (row 0, column 0) sits at the MSB end of the flat bitmap.
    for (genvar i = 0; i < NE; i++) begin : g_unpack
        assign entries[i] = BITMAP[NE*EW-1-i*EW -: EW];
    end

    assign {en, rgb} = entries[{row, col}];
endmodule

// File: rtl/game_sprite_display_scaled.sv
// game_sprite_display_scaled: scaled, mirrorable sprite overlay with a 3-stage pixel pipeline
// (offsets/compares, hit+index, bitmap lookup).
module game_sprite_display_scaled
    import game_sprite_display_scaled_pkg::*;
#(
    parameter int SPRITE_WIDTH = 8,
    parameter int SPRITE_HEIGHT = 8,
    parameter logic [SPRITE_HEIGHT*SPRITE_WIDTH*(1+RGBW)-1:0] BITMAP = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            frame_start,
    input  logic            pixel_valid,
    input  logic [XW-1:0]   pixel_x,
    input  logic [YW-1:0]   pixel_y,
    input  logic [XW-1:0]   sprite_x,
    input  logic [YW-1:0]   sprite_y,
    input  logic [1:0]      scale,
    input  logic            mirror_x,
    input  logic            mirror_y,
    output logic            sprite_within_screen,
    output logic [XW-1:0]   sprite_out_left,
    output logic [XW-1:0]   sprite_out_right,
    output logic [YW-1:0]   sprite_out_top,
    output logic [YW-1:0]   sprite_out_bottom,
    output logic            rgb_en,
    output logic [RGBW-1:0] rgb
);
    localparam int CW = $clog2(SPRITE_WIDTH);
    localparam int RW = $clog2(SPRITE_HEIGHT);
    localparam logic [XW:0] SPW = (XW+1)'(SPRITE_WIDTH);
    localparam logic [YW:0] SPH = (YW+1)'(SPRITE_HEIGHT);
    localparam logic [XW:0] ONE_X = (XW+1)'(1);
    localparam logic [YW:0] ONE_Y = (YW+1)'(1);
    localparam logic [XW:0] MAX_X = (XW+1)'(SCR_W - 1);
    localparam logic [YW:0] MAX_Y = (YW+1)'(SCR_H - 1);

    sprite_attr_t act, req, eff;
    logic [XW:0] left, right, px;
    logic [YW:0] top, bottom, py;

    logic          v1, v2;
    logic [3:0]    cmp1;
    logic [XW:0]   dx1;
    logic [YW:0]   dy1;
    logic [1:0]    s1;
    logic          mx1, my1;
    logic [CW-1:0] col, col2;
    logic [RW-1:0] row, row2;
    logic          rom_en;
    logic [RGBW-1:0] rom_rgb;

    // A pixel in the frame_start cycle already sees the newly requested attributes.
    assign req = '{x: sprite_x, y: sprite_y, s: shift_of(scale), mx: mirror_x, my: mirror_y};
    assign eff = frame_start ? req : act;

    // Footprint is computed one bit wider so edges past the port range never wrap.
    assign left   = {1'b0, eff.x};
    assign top    = {1'b0, eff.y};
    assign right  = left + (SPW << eff.s) - ONE_X;
    assign bottom = top + (SPH << eff.s) - ONE_Y;
    assign px     = {1'b0, pixel_x};
    assign py     = {1'b0, pixel_y};

    assign col = mx1 ? ~CW'(dx1 >> s1) : CW'(dx1 >> s1);
    assign row = my1 ? ~RW'(dy1 >> s1) : RW'(dy1 >> s1);

    game_sprite_bitmap_rom #(
        .SPRITE_WIDTH (SPRITE_WIDTH),
        .SPRITE_HEIGHT(SPRITE_HEIGHT),
        .BITMAP       (BITMAP)
    ) u_rom (
        .row(row2),
        .col(col2),
        .en (rom_en),
        .rgb(rom_rgb)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act                  <= '0;
            sprite_within_screen <= 1'b0;
            sprite_out_left      <= '0;
            sprite_out_right     <= '0;
            sprite_out_top       <= '0;
            sprite_out_bottom    <= '0;
            v1                   <= 1'b0;
            cmp1                 <= '0;
            dx1                  <= '0;
            dy1                  <= '0;
            s1                   <= '0;
            mx1                  <= 1'b0;
            my1                  <= 1'b0;
            v2                   <= 1'b0;
            col2                 <= '0;
            row2                 <= '0;
            rgb_en               <= 1'b0;
            rgb                  <= '0;
        end else begin
            if (frame_start) begin
                act                  <= req;
                sprite_out_left      <= eff.x;
                sprite_out_top       <= eff.y;
                sprite_out_right     <= right[XW-1:0];
                sprite_out_bottom    <= bottom[YW-1:0];
                sprite_within_screen <= (right <= MAX_X) && (bottom <= MAX_Y);
            end
            v1   <= pixel_valid;
            cmp1 <= {px >= left, px <= right, py >= top, py <= bottom};
            dx1  <= px - left;
            dy1  <= py - top;
            s1   <= eff.s;
            mx1  <= eff.mx;
            my1  <= eff.my;
            v2   <= v1 && (&cmp1);
            col2 <= col;
            row2 <= row;
            rgb_en <= v2 && rom_en;
            if (v2 && rom_en)
                rgb <= rom_rgb;
        end
    end
endmodule

// File: tb/tb_game_sprite_display_scaled.sv
// tb_game_sprite_display_scaled: directed vector table plus hand sequences for
// attribute latching, frame_start bypass and mid-stream reset.
module tb_game_sprite_display_scaled;
    import game_sprite_display_scaled_pkg::*;

    localparam int BW = 8 * 8 * (1 + RGBW);

    function automatic logic [RGBW:0] ent(input int r, input int c);
        return {((r * 8 + c) % 5) != 2, RGBW'((r * 2 + c + 1) & 7)};
    endfunction

    function automatic logic [BW-1:0] make_bm();
        logic [BW-1:0] b;
        b = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[BW-1-(r*8+c)*(1+RGBW) -: (1+RGBW)] = ent(r, c);
        return b;
    endfunction

    localparam logic [BW-1:0] BM = make_bm();

    logic            clk = 1'b0;
    logic            reset_n, frame_start, pixel_valid, mirror_x, mirror_y;
    logic [XW-1:0]   pixel_x, sprite_x;
    logic [YW-1:0]   pixel_y, sprite_y;
    logic [1:0]      scale;
    logic            sprite_within_screen, rgb_en;
    logic [XW-1:0]   sprite_out_left, sprite_out_right;
    logic [YW-1:0]   sprite_out_top, sprite_out_bottom;
    logic [RGBW-1:0] rgb;

    game_sprite_display_scaled #(.SPRITE_WIDTH(8), .SPRITE_HEIGHT(8), .BITMAP(BM)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .pixel_valid(pixel_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .scale(scale), .mirror_x(mirror_x), .mirror_y(mirror_y),
        .sprite_within_screen(sprite_within_screen),
        .sprite_out_left(sprite_out_left), .sprite_out_right(sprite_out_right),
        .sprite_out_top(sprite_out_top), .sprite_out_bottom(sprite_out_bottom),
        .rgb_en(rgb_en), .rgb(rgb)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit cfg;
        int sx, sy, sc, mx, my;
        int px, py, en, r, c;
        int rt, bt, w;
    } vec_t;

    vec_t vecs[$];
    int n_checks = 0;
    int n_fail = 0;
    logic [RGBW-1:0] last_rgb = '0;

    function automatic vec_t cfgv(input int sx, sy, sc, mx, my, rt, bt, w);
        vec_t v;
        v = '{default: 0};
        v.cfg = 1; v.sx = sx; v.sy = sy; v.sc = sc; v.mx = mx; v.my = my;
        v.rt = rt; v.bt = bt; v.w = w;
        return v;
    endfunction

    function automatic vec_t pixv(input int px, py, en, r, c);
        vec_t v;
        v = '{default: 0};
        v.px = px; v.py = py; v.en = en; v.r = r; v.c = c;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_sprite(input int sx, sy, sc, mx, my);
        sprite_x = XW'(sx); sprite_y = YW'(sy); scale = 2'(sc);
        mirror_x = (mx != 0); mirror_y = (my != 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send(input int px, py, en, r, c, id);
        logic [RGBW:0] e;
        pixel_x = XW'(px); pixel_y = YW'(py); pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
        tick();
        chk($sformatf("v%0d early rgb_en", id), int'(rgb_en), 0);
        tick();
        chk($sformatf("v%0d rgb_en (%0d,%0d)", id, px, py), int'(rgb_en), en);
        e = ent(r, c);
        if (en != 0) last_rgb = e[RGBW-1:0];
        chk($sformatf("v%0d rgb", id), int'(rgb), int'(last_rgb));
    endtask

    task automatic chk_cfg(input int sx, sy, rt, bt, w, id);
        chk($sformatf("c%0d out_left", id), int'(sprite_out_left), sx);
        chk($sformatf("c%0d out_top", id), int'(sprite_out_top), sy);
        chk($sformatf("c%0d out_right", id), int'(sprite_out_right), rt);
        chk($sformatf("c%0d out_bottom", id), int'(sprite_out_bottom), bt);
        chk($sformatf("c%0d within", id), int'(sprite_within_screen), w);
    endtask

    initial begin
        vecs.push_back(cfgv(100, 50, 0, 0, 0, 107, 57, 1));
        vecs.push_back(pixv(100, 50, 1, 0, 0));
        vecs.push_back(pixv(108, 50, 0, 0, 0));
        vecs.push_back(pixv(107, 57, 1, 7, 7));
        vecs.push_back(pixv(102, 50, 0, 0, 2));
        vecs.push_back(pixv(99, 50, 0, 0, 0));
        vecs.push_back(pixv(103, 51, 1, 1, 3));
        vecs.push_back(pixv(100, 58, 0, 0, 0));
        vecs.push_back(cfgv(100, 50, 1, 0, 0, 115, 65, 1));
        vecs.push_back(pixv(115, 65, 1, 7, 7));
        vecs.push_back(pixv(116, 50, 0, 0, 0));
        vecs.push_back(pixv(101, 51, 1, 0, 0));
        vecs.push_back(pixv(102, 53, 1, 1, 1));
        vecs.push_back(cfgv(100, 50, 2, 0, 0, 131, 81, 1));
        vecs.push_back(pixv(131, 81, 1, 7, 7));
        vecs.push_back(pixv(132, 50, 0, 0, 0));
        vecs.push_back(pixv(104, 58, 0, 2, 1));
        vecs.push_back(pixv(105, 54, 1, 1, 1));
        vecs.push_back(cfgv(100, 50, 3, 0, 0, 107, 57, 1));
        vecs.push_back(pixv(108, 50, 0, 0, 0));
        vecs.push_back(pixv(107, 57, 1, 7, 7));
        vecs.push_back(cfgv(100, 50, 0, 1, 1, 107, 57, 1));
        vecs.push_back(pixv(100, 50, 1, 7, 7));
        vecs.push_back(pixv(107, 50, 1, 7, 0));
        vecs.push_back(pixv(100, 57, 0, 0, 7));
        vecs.push_back(cfgv(100, 50, 0, 1, 0, 107, 57, 1));
        vecs.push_back(pixv(101, 50, 1, 0, 6));
        vecs.push_back(cfgv(636, 470, 0, 0, 0, 643, 477, 0));
        vecs.push_back(pixv(639, 470, 1, 0, 3));
        vecs.push_back(pixv(640, 470, 1, 0, 4));
        vecs.push_back(pixv(635, 470, 0, 0, 0));
        vecs.push_back(cfgv(632, 472, 0, 0, 0, 639, 479, 1));
        vecs.push_back(pixv(639, 479, 1, 7, 7));
        vecs.push_back(cfgv(600, 470, 1, 0, 0, 615, 485, 0));

        reset_n = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
        pixel_x = '0; pixel_y = '0; sprite_x = '0; sprite_y = '0;
        scale = '0; mirror_x = 1'b0; mirror_y = 1'b0;
        tick();
        tick();
        chk("reset rgb_en", int'(rgb_en), 0);
        chk("reset rgb", int'(rgb), 0);
        chk_cfg(0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            if (vecs[i].cfg) begin
                set_sprite(vecs[i].sx, vecs[i].sy, vecs[i].sc, vecs[i].mx, vecs[i].my);
                chk_cfg(vecs[i].sx, vecs[i].sy, vecs[i].rt, vecs[i].bt, vecs[i].w, i);
            end else begin
                send(vecs[i].px, vecs[i].py, vecs[i].en, vecs[i].r, vecs[i].c, i);
            end
        end

        // Attribute changes without frame_start must not move the sprite.
        set_sprite(100, 50, 0, 0, 0);
        sprite_x = XW'(200);
        send(100, 50, 1, 0, 0, 100);
        send(200, 50, 0, 0, 0, 101);
        chk("held out_left", int'(sprite_out_left), 100);
        set_sprite(200, 50, 0, 0, 0);
        chk("relatched out_left", int'(sprite_out_left), 200);
        send(200, 50, 1, 0, 0, 102);
        send(207, 57, 1, 7, 7, 103);
        send(100, 50, 0, 0, 0, 104);

        // Pixel in the frame_start cycle uses the new attributes.
        sprite_x = XW'(300);
        frame_start = 1'b1;
        pixel_x = XW'(300); pixel_y = YW'(50); pixel_valid = 1'b1;
        tick();
        frame_start = 1'b0; pixel_valid = 1'b0;
        tick();
        tick();
        chk("bypass rgb_en", int'(rgb_en), 1);
        chk("bypass out_left", int'(sprite_out_left), 300);

        // Mid-stream reset with a continuous hit stream.
        set_sprite(100, 50, 0, 0, 0);
        pixel_x = XW'(100); pixel_y = YW'(50); pixel_valid = 1'b1;
        repeat (4) tick();
        chk("stream rgb_en", int'(rgb_en), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset rgb_en", int'(rgb_en), 0);
        chk("async reset rgb", int'(rgb), 0);
        chk("async reset out_left", int'(sprite_out_left), 0);
        last_rgb = '0;
        tick();
        reset_n = 1'b1;
        chk("post reset out_right", int'(sprite_out_right), 0);
        chk("post reset within", int'(sprite_within_screen), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post reset miss %0d", k), int'(rgb_en), 0);
        end
        pixel_x = '0; pixel_y = '0;
        tick();
        chk("first hit +1", int'(rgb_en), 0);
        tick();
        chk("first hit +2", int'(rgb_en), 0);
        tick();
        chk("first hit +3", int'(rgb_en), 1);
        chk("first hit rgb", int'(rgb), 1);
        pixel_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/game_sprite_display_scaled.md
GAME_SPRITE_DISPLAY_SCALED -- requirements
Module: game_sprite_display_scaled

Interface
REQ-001 Parameter SPRITE_WIDTH, default 8, bitmap columns; power of two, 2..32.
REQ-002 Parameter SPRITE_HEIGHT, default 8, bitmap rows; power of two, 2..32.
REQ-003 Parameter BITMAP, default all-zero, flat bitmap of SPRITE_HEIGHT*SPRITE_WIDTH*(1+`RGB_WIDTH) bits; row 0 at MSB end, column 0 MSB-most within a row; each entry is {enable, rgb}.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 frame_start  in  1  single-cycle strobe; latches the sprite attributes.
REQ-008 pixel_valid  in  1  pixel_x/pixel_y carry a real pixel this cycle.
REQ-009 pixel_x  in  `X_WIDTH  scan x; pixel_y  in  `Y_WIDTH  scan y.
REQ-010 sprite_x  in  `X_WIDTH  and sprite_y  in  `Y_WIDTH  requested top-left corner.
REQ-011 scale  in  2  0 = x1, 1 = x2, 2 = x4, 3 = treated as x1.
REQ-012 mirror_x  in  1  and mirror_y  in  1  horizontal/vertical flip.
REQ-013 sprite_within_screen  out  1  active footprint fully on screen.
REQ-014 sprite_out_left/right  out  `X_WIDTH  and sprite_out_top/bottom  out  `Y_WIDTH  active footprint edges, inclusive.
REQ-015 rgb_en  out  1  and rgb  out  `RGB_WIDTH  sprite pixel colour and its valid.

Function
REQ-016 Active attributes (x, y, scale s, mirrors) SHALL load from the inputs on the edge where frame_start=1 and hold otherwise; changes without frame_start SHALL not affect output.
REQ-017 A pixel presented in the frame_start cycle SHALL use the newly presented attributes (bypass), not the previous active set.
REQ-018 Footprint: left=x, right=x+(SPRITE_WIDTH<<s)-1, top=y, bottom=y+(SPRITE_HEIGHT<<s)-1, all evaluated at width+1 bits with no wrap-around.
REQ-019 Hit SHALL be left<=pixel_x<=right and top<=pixel_y<=bottom, unsigned, extended width.
REQ-020 Column = (pixel_x-left)>>s, row = (pixel_y-top)>>s; mirror_x replaces column with SPRITE_WIDTH-1-column, mirror_y likewise for row.
REQ-021 Pipeline SHALL be exactly 3 stages: offsets/compares, hit+index, bitmap lookup; rgb_en valid exactly 3 cycles after the pixel_valid cycle, one pixel per clock, no stalls.
REQ-022 rgb_en SHALL be 1 only if pixel_valid, hit and entry enable bit are all 1; enable=0 is transparent.
REQ-023 rgb SHALL update only when rgb_en is 1 and hold its value otherwise.
REQ-024 sprite_within_screen SHALL be right<=`SCREEN_WIDTH-1 and bottom<=`SCREEN_HEIGHT-1 (carry bit clear); it and sprite_out_* SHALL update 1 cycle after the latching frame_start; sprite_out_right/bottom truncate to port width.

Reset
REQ-025 reset_n=0 SHALL immediately clear all outputs, active attributes (s=0, mirrors=0) and all pipeline valid bits.
REQ-026 Reset mid-stream SHALL discard in-flight pixels; after release no rgb_en=1 earlier than 3 cycles after a new pixel_valid.

Structure
REQ-027 `X_WIDTH, `Y_WIDTH, `RGB_WIDTH, `SCREEN_WIDTH, `SCREEN_HEIGHT SHALL come from the shared game_config.vh.
REQ-028 Bitmap lookup SHALL be a sub-module game_sprite_bitmap_rom (row, column -> {enable, rgb}, parametrised by size and BITMAP); the registered lookup stage lives in the parent.

Verification (8x8, `RGB_WIDTH=3, 640x480)
REQ-029 s=0, sprite (100,50), frame_start, pixel (100,50) -> 3 cycles later rgb_en/rgb = BITMAP row0 col0; pixel (108,50) -> rgb_en=0.
REQ-030 s=1, sprite (100,50): pixel (115,65) -> row7 col7 entry; pixel (116,50) -> rgb_en=0; sprite_out_right=115, sprite_out_bottom=65.
REQ-031 mirror_x=1, mirror_y=1, pixel (100,50) -> row7 col7 entry.
REQ-032 sprite_x set to 200 without frame_start -> hits remain at 100..107; after frame_start -> hits at 200..207, sprite_out_left=200 next cycle.
REQ-033 sprite (636,470) s=0 -> sprite_within_screen=0, sprite_out_right=643; pixel (639,470) -> row0 col3 entry.
REQ-034 continuous valid pixels, reset_n pulsed low 1 cycle -> rgb_en=0 at once; first rgb_en=1 exactly 3 cycles after first post-reset hit.
